// File: rtl/weight_bank_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weight_bank_stream_pkg
// Description : Shared types and helpers for the weight bank stream block:
//               playback FSM encoding, a ceil-log2 helper and the lane-slice
//               macro used to pick one neuron's weight out of a wide row.
// Revision    : 1.0 - initial release
// ============================================================================

// Selects lane n (width w) from a row bus where lane 0 sits in the LSBs.
`define WBS_LANE_SLICE(bus, n, w) bus[(n)*(w) +: (w)]

package weight_bank_stream_pkg;

  localparam int STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wbs_state_e;

  // Number of bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/weight_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : weight_play_ctrl
// Description : Playback sequencer for the weight bank. Walks the read row
//               counter from 0 to NUM_WEIGHT-1 under valid/ready backpressure,
//               requests a registered array read per issued row and produces
//               the beat valid/addr/last qualifiers plus the done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_play_ctrl
  import weight_bank_stream_pkg::*;
#(
  parameter int NUM_WEIGHT = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  out_ready_i,
  output logic                  idle_o,
  output logic                  busy_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_row_o,
  output logic                  out_valid_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  out_last_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_WEIGHT - 1);

  wbs_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rrow_q, rrow_d;
  logic                  issued_all_q, issued_all_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  last_q, last_d;
  logic                  rd_en;

  // State and beat registers; reset returns to IDLE with quiet outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rrow_q       <= '0;
      issued_all_q <= 1'b0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rrow_q       <= rrow_d;
      issued_all_q <= issued_all_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
    end
  end

  // Next-state, row issue and beat qualifier logic.
  always_comb begin
    state_d      = state_q;
    rrow_d       = rrow_q;
    issued_all_d = issued_all_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    last_d       = last_q;
    rd_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d      = ST_RUN;
          rrow_d       = '0;
          issued_all_d = 1'b0;
        end
      end

      ST_RUN: begin
        // The output slot is free when empty or being consumed this cycle.
        if (!valid_q || out_ready_i) begin
          if (!issued_all_q) begin
            rd_en   = 1'b1;
            valid_d = 1'b1;
            addr_d  = rrow_q;
            last_d  = (rrow_q == LAST_ROW);
            // Hold the counter on the final row; a flag stops further issue
            // so the counter never needs to reach NUM_WEIGHT.
            if (rrow_q == LAST_ROW) begin
              issued_all_d = 1'b1;
            end else begin
              rrow_d = rrow_q + 1'b1;
            end
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
        if (valid_q && out_ready_i && last_q) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign idle_o      = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DRAIN);
  assign rd_en_o     = rd_en;
  assign rd_row_o    = rrow_q;
  assign out_valid_o = valid_q;
  assign out_addr_o  = addr_q;
  assign out_last_o  = last_q;

endmodule

`default_nettype wire

// File: rtl/weight_bank_stream.sv
`default_nettype none
// ============================================================================
// Module      : weight_bank_stream
// Description : Multi-neuron weight store for one fully-connected layer.
//               Weights are loaded one lane at a time over a valid/ready
//               stream with an auto-incrementing lane/row pointer, then played
//               back row by row with all lanes presented in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_bank_stream
  import weight_bank_stream_pkg::*;
#(
  parameter int    NUM_WEIGHT  = 784,
  parameter int    NUM_NEURONS = 4,
  parameter int    DATA_WIDTH  = 16,
  parameter int    ADDR_WIDTH  = 10,
  parameter int    LANE_WIDTH  = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              load_restart,
  output logic                              load_last,
  input  logic                              start,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]             out_addr,
  output logic                              out_last,
  output logic                              done
);

  localparam int ROW_BITS = NUM_NEURONS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(NUM_WEIGHT - 1);
  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(NUM_NEURONS - 1);

  // Reject parameter sets whose pointers cannot reach every row or lane.
  if (ADDR_WIDTH < clog2(NUM_WEIGHT)) begin : g_bad_addr_width
    $error("ADDR_WIDTH too small for NUM_WEIGHT");
  end
  if (LANE_WIDTH < clog2(NUM_NEURONS)) begin : g_bad_lane_width
    $error("LANE_WIDTH too small for NUM_NEURONS");
  end

  logic [ROW_BITS-1:0]   mem_q [NUM_WEIGHT];
  logic [ADDR_WIDTH-1:0] wrow_q, wrow_d;
  logic [LANE_WIDTH-1:0] wlane_q, wlane_d;
  logic [ROW_BITS-1:0]   out_data_q;
  logic                  in_accept;
  logic                  ctrl_idle;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_row;

  // Loading is only open while playback is idle.
  assign in_ready  = ctrl_idle;
  assign in_accept = in_valid && ctrl_idle;
  assign load_last = (wlane_q == LAST_LANE) && (wrow_q == LAST_ROW);

  // Write-pointer update: rows advance first, lane steps on row wrap;
  // restart wins over the increment of an accepted beat.
  always_comb begin
    wrow_d  = wrow_q;
    wlane_d = wlane_q;
    if (load_restart) begin
      wrow_d  = '0;
      wlane_d = '0;
    end else if (in_accept) begin
      if (wrow_q == LAST_ROW) begin
        wrow_d  = '0;
        wlane_d = (wlane_q == LAST_LANE) ? '0 : wlane_q + 1'b1;
      end else begin
        wrow_d = wrow_q + 1'b1;
      end
    end
  end

  // Write-pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrow_q  <= '0;
      wlane_q <= '0;
    end else begin
      wrow_q  <= wrow_d;
      wlane_q <= wlane_d;
    end
  end

  // Lane write into the wide array; contents are never reset.
  always_ff @(posedge clk) begin
    if (in_accept) begin
      `WBS_LANE_SLICE(mem_q[wrow_q], wlane_q, DATA_WIDTH) <= in_data;
    end
  end

  // Registered row read, loaded only when the controller issues a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
    end else if (rd_en) begin
      out_data_q <= mem_q[rd_row];
    end
  end

  assign out_data = out_data_q;

  weight_play_ctrl #(
    .NUM_WEIGHT (NUM_WEIGHT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .out_ready_i (out_ready),
    .idle_o      (ctrl_idle),
    .busy_o      (busy),
    .rd_en_o     (rd_en),
    .rd_row_o    (rd_row),
    .out_valid_o (out_valid),
    .out_addr_o  (out_addr),
    .out_last_o  (out_last),
    .done_o      (done)
  );

endmodule

`default_nettype wire
